// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings (RV32M funct3), FSM state enum and default width.
package mdu_iter_pkg;

  localparam int MDU_XLEN = 32;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mdu_state_e;

  // Divide family is identified by funct3[2].
  function automatic logic mdu_is_div(input mdu_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_iter_signfix.sv
// Combinational two's-complement conditional negation.
// Ports: i_a/i_b values, i_neg_a/i_neg_b per-value negate, i_wide
// treats {i_a,i_b} as one 2W value negated by i_neg_a; o_a/o_b results.
module mdu_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_neg_a,
  input  logic         i_neg_b,
  input  logic         i_wide,
  output logic [W-1:0] o_a,
  output logic [W-1:0] o_b
);

  logic [2*W-1:0] w_cat;
  logic [2*W-1:0] w_cat_n;
  logic [W-1:0]   w_a_n;
  logic [W-1:0]   w_b_n;

  assign w_cat   = {i_a, i_b};
  assign w_cat_n = ~w_cat + {{(2*W-1){1'b0}}, 1'b1};
  assign w_a_n   = ~i_a + {{(W-1){1'b0}}, 1'b1};
  assign w_b_n   = ~i_b + {{(W-1){1'b0}}, 1'b1};

  always_comb begin
    o_a = i_a;
    o_b = i_b;
    if (i_wide) begin
      if (i_neg_a) begin
        {o_a, o_b} = w_cat_n;
      end
    end else begin
      if (i_neg_a) o_a = w_a_n;
      if (i_neg_b) o_b = w_b_n;
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, fixed XLEN+2 edge latency from accept to done.
// Ports: i_clk, i_rst (sync, active-high), i_start, i_op (funct3),
// i_src1, i_src2; o_busy, o_done (1-cycle pulse), o_result.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  mdu_state_e        r_state;
  mdu_op_e           r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic              r_neg_a;
  logic              r_neg_b;
  logic [XLEN-1:0]   r_fix;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  mdu_op_e           w_op;
  logic              w_s1s;
  logic              w_s2s;
  logic              w_n1;
  logic              w_n2;
  logic [XLEN-1:0]   w_mag1;
  logic [XLEN-1:0]   w_mag2;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic [2*XLEN-1:0] w_addend;
  logic              w_div;
  logic [XLEN-1:0]   w_fa;
  logic [XLEN-1:0]   w_fb;
  logic [XLEN-1:0]   w_sel;

  assign w_op = mdu_op_e'(i_op);

  always_comb begin
    w_s1s = 1'b0;
    w_s2s = 1'b0;
    case (w_op)
      MDU_MULH, MDU_DIV, MDU_REM: begin
        w_s1s = 1'b1;
        w_s2s = 1'b1;
      end
      MDU_MULHSU: w_s1s = 1'b1;
      default: ;
    endcase
  end

  assign w_n1 = w_s1s & i_src1[XLEN-1];
  assign w_n2 = w_s2s & i_src2[XLEN-1];

  mdu_signfix #(.W(XLEN)) u_in (
    .i_a     (i_src1),
    .i_b     (i_src2),
    .i_neg_a (w_n1),
    .i_neg_b (w_n2),
    .i_wide  (1'b0),
    .o_a     (w_mag1),
    .o_b     (w_mag2)
  );

  // Restoring divide step: shift in next dividend bit, subtract if it fits.
  assign w_shift = {r_rem, r_a[r_cnt]};
  assign w_ge    = w_shift >= {1'b0, r_b};
  assign w_sub   = w_shift[XLEN-1:0] - r_b;

  // MSB-first shift-add multiply step.
  assign w_addend = r_b[r_cnt] ? {{XLEN{1'b0}}, r_a} : '0;

  assign w_div = mdu_is_div(r_op);

  mdu_signfix #(.W(XLEN)) u_out (
    .i_a     (w_div ? r_quo : r_prod[2*XLEN-1:XLEN]),
    .i_b     (w_div ? r_rem : r_prod[XLEN-1:0]),
    .i_neg_a (r_neg_a),
    .i_neg_b (r_neg_b),
    .i_wide  (~w_div),
    .o_a     (w_fa),
    .o_b     (w_fb)
  );

  assign w_sel = (r_op == MDU_MUL || r_op == MDU_REM || r_op == MDU_REMU)
               ? w_fb : w_fa;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_op     <= MDU_MUL;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_prod   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_fix    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_op    <= w_op;
            r_a     <= w_mag1;
            r_b     <= w_mag2;
            r_cnt   <= CNT_W'(XLEN - 1);
            r_prod  <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            // Quotient sign is forced positive on divide-by-zero so the
            // all-ones result survives the fix-up.
            r_neg_a <= w_op[2] ? ((w_n1 ^ w_n2) & (|i_src2))
                               : (w_n1 ^ w_n2);
            r_neg_b <= w_n1;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (w_div) begin
            r_rem        <= w_ge ? w_sub : w_shift[XLEN-1:0];
            r_quo[r_cnt] <= w_ge;
          end else begin
            r_prod <= {r_prod[2*XLEN-2:0], 1'b0} + w_addend;
          end
          if (r_cnt == '0) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          r_fix   <= w_sel;
          r_state <= DONE;
        end
        DONE: begin
          r_result <= r_fix;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (XLEN=32): arithmetic/timing model
// compared every cycle, plus directed literal vectors.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          m_cnt  = -1;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_pend = '0;

  mdu_iter #(.XLEN(32)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_op     (op),
    .i_src1   (src1),
    .i_src2   (src2),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [2:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'h0, a});
    longint      ub = longint'({32'h0, b});
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = 64'(ua / ub); return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = 64'(ua % ub); return p[31:0];
      end
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h want %0h", nm, cyc, got, want);
    end
  endtask

  // Model: accept when idle, done exactly 34 edges later.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_cnt  = -1;
      m_done = 1'b0;
      m_res  = '0;
    end else begin
      m_done = 1'b0;
      if (m_cnt >= 0) begin
        m_cnt++;
        if (m_cnt == 34) begin
          m_done = 1'b1;
          m_res  = m_pend;
          m_cnt  = -1;
        end
      end else if (start) begin
        m_pend = ref_op(op, src1, src2);
        m_cnt  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy", 64'(busy), 64'(m_cnt >= 0));
      chk("done", 64'(done), 64'(m_done));
      chk("result", 64'(result), 64'(m_res));
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, output int acc);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk);
    #1 acc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int acc, input string nm,
                           input logic [31:0] exp);
    int n   = 0;
    bit got = 1'b0;
    while (!got && n < 80) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    chk({nm, " done_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({nm, " latency"}, 64'(cyc - acc), 64'd34);
      chk({nm, " value"}, 64'(result), 64'(exp));
    end
  endtask

  task automatic run(input string nm, input logic [2:0] o,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    int acc;
    chk({nm, " model"}, 64'(ref_op(o, a, b)), 64'(exp));
    issue(o, a, b, acc);
    wait_done(acc, nm, exp);
  endtask

  typedef struct {
    string       nm;
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$] = '{
    '{"mul_7_m3",     3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{"mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{"mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{"mulhsu_m1",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{"mulh_m3_5",    3'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF},
    '{"div_by0",      3'd4, 32'd100,       32'd0,         32'hFFFF_FFFF},
    '{"rem_by0",      3'd6, 32'd100,       32'd0,         32'd100},
    '{"div_neg_by0",  3'd4, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FFFF},
    '{"rem_neg_by0",  3'd6, 32'hFFFF_FF9C, 32'd0,         32'hFFFF_FF9C},
    '{"div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{"rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0},
    '{"div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
    '{"rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
    '{"div_7_m2",     3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD},
    '{"rem_7_m2",     3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1},
    '{"divu_max_2",   3'd5, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF},
    '{"remu_100_7",   3'd7, 32'd100,       32'd7,         32'd2}
  };

  initial begin
    int acc;
    int acc2;
    int nd;
    rst = 1'b1; start = 1'b0; op = '0; src1 = '0; src2 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) run(vecs[i].nm, vecs[i].o, vecs[i].a,
                          vecs[i].b, vecs[i].exp);

    // Starts while busy and in the DONE-state cycle are ignored;
    // a start during the done pulse is accepted immediately.
    issue(3'd0, 32'd3, 32'd5, acc);
    while (cyc < acc + 10) @(negedge clk);
    start = 1'b1; op = 3'd4; src1 = 32'd99; src2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 33) @(negedge clk);
    start = 1'b1; op = 3'd4; src1 = 32'd1; src2 = 32'd1;
    @(negedge clk);
    chk("busy_ign done", 64'(done), 64'd1);
    chk("busy_ign latency", 64'(cyc - acc), 64'd34);
    chk("busy_ign value", 64'(result), 64'd15);
    op = 3'd0; src1 = 32'd4; src2 = 32'd5;
    @(posedge clk);
    #1 acc2 = cyc;
    chk("b2b spacing", 64'(acc2 - acc), 64'd35);
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy", 64'(busy), 64'd1);
    wait_done(acc2, "b2b", 32'd20);

    // Reset mid-operation aborts with no done pulse.
    issue(3'd4, 32'd100, 32'd7, acc);
    while (cyc < acc + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("abort no_done", 64'(nd), 64'd0);
    run("mulhu_2_3", 3'd3, 32'd2, 32'd3, 32'd0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal values 8 to 64, even.
REQ-002 Parameter CNT_W, default $clog2(XLEN): width of the iteration counter.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request; accepted only on a rising edge where busy=0.
REQ-006 op  input  3  operation, RV32M funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 src1  input  XLEN  multiplicand or dividend; captured on the accepting edge.
REQ-008 src2  input  XLEN  multiplier or divisor; captured on the accepting edge.
REQ-009 busy  output  1  high from the accepting edge until the edge that raises done.
REQ-010 done  output  1  one-cycle pulse; result is valid in this cycle.
REQ-011 result  output  XLEN  operation result; held stable from done until the next accepting edge.

Function
REQ-012 The state machine SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-013 IDLE goes to CALC on start; the accepting edge latches op, converts signed operands to magnitudes and records the result sign.
REQ-014 CALC SHALL run exactly XLEN iterations, one per cycle, with the counter going from XLEN-1 down to 0; CALC then goes to FIX.
REQ-015 Multiply SHALL use radix-2 shift-add into a 2*XLEN product; MUL returns the low XLEN bits, MULH/MULHSU/MULHU return the high XLEN bits.
REQ-016 Signedness SHALL be: MULH signed x signed; MULHSU signed src1 x unsigned src2; MULHU and DIVU/REMU unsigned; DIV/REM signed.
REQ-017 Divide SHALL use radix-2 restoring division producing an XLEN quotient and an XLEN remainder.
REQ-018 FIX SHALL apply two's-complement sign correction; the quotient is negative when the operand signs differ, and the remainder takes the dividend's sign.
REQ-019 FIX goes to DONE, and DONE goes to IDLE after one cycle.
REQ-020 Latency SHALL be fixed for every op and operand, including the special cases: done=1 exactly XLEN+2 edges after the accepting edge.
REQ-021 Divide by zero: DIV/DIVU return all ones; REM/REMU return src1 unchanged.
REQ-022 Signed overflow (src1 = 2^(XLEN-1), src2 = all ones): DIV returns src1; REM returns 0.
REQ-023 A start while busy=1 SHALL be ignored, with no effect on state, operands or result.
REQ-024 A start during the DONE cycle SHALL be ignored; a start in the cycle after done is accepted.
REQ-025 Back-to-back throughput SHALL be one operation per XLEN+3 cycles.
REQ-026 All arithmetic SHALL be modulo 2^XLEN; no status flags are produced.

Reset
REQ-027 When rst=1 on an edge: state goes to IDLE, and busy=0, done=0, result=0, counter=0, with internal accumulators cleared.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts is accepted normally.
REQ-029 rst SHALL take priority over start on the same edge.

Structure
REQ-030 A shared package SHALL hold the op encodings (MDU_MUL … MDU_REMU), the state enum and the default XLEN constant.
REQ-031 Sub-module mdu_signfix (combinational) SHALL handle operand magnitude conversion and result negation, and is instantiated twice.
REQ-032 The iterative datapath SHALL NOT use the * or / operators.

Verification (XLEN=32)
REQ-033 MUL with src1=7, src2=0xFFFFFFFD -> result 0xFFFFFFEB, with done exactly 34 edges after the accepting edge.
REQ-034 MULH with 0x80000000 x 0x80000000 -> 0x40000000; MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 DIV 100 / 0 -> 0xFFFFFFFF; REM 100 / 0 -> 100; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0; each with latency 34.
REQ-036 DIV -7 / 2 -> 0xFFFFFFFD and REM -7 / 2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF.
REQ-037 Start MUL 3x5, pulse start with op=DIV at cycle 10 -> ignored; result is 15 at latency 34; a start in the cycle after done is accepted.
REQ-038 Start DIV, assert rst at cycle 20 -> no done pulse and result=0; a new MULHU 2x3 then completes with 0 after 34 edges.
